// File: rtl/neuron_lif_array_if.sv
// Impulse and spike channel of the LIF neuron array.
// The sender side (master) offers impulses and observes spikes; the array is the slave.
interface neuron_lif_array_if #(
   parameter int size_vmem = 16,
   parameter int size_idx  = 4
);
   logic                        acc_valid;
   logic                        acc_ready;
   logic        [size_idx-1:0]  acc_idx;
   logic signed [size_vmem-1:0] acc_weight;
   logic                        spike_valid;
   logic        [size_idx-1:0]  spike_idx;

   modport master (
      output acc_valid, acc_idx, acc_weight,
      input  acc_ready, spike_valid, spike_idx
   );

   modport slave (
      input  acc_valid, acc_idx, acc_weight,
      output acc_ready, spike_valid, spike_idx
   );
endinterface

// File: rtl/neuron_lif_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array: saturating impulse
// accumulation while idle, then one leak/threshold sweep per timestep pulse.
module neuron_lif_array #(
   parameter int NUM_NEURONS = 16,
   parameter int size_vmem   = 16,
   parameter int size_idx    = 4,
   parameter int size_refrac = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   neuron_lif_array_if.slave           bus,
   input  logic                        step_start,
   input  logic signed [size_vmem-1:0] threshold,
   input  logic        [3:0]           leak_shift,
   input  logic                        reset_mode,
   input  logic        [size_refrac-1:0] refrac_cfg,
   output logic                        busy,
   output logic                        step_done,
   input  logic        [size_idx-1:0]  rd_idx,
   output logic signed [size_vmem-1:0] rd_vmem
);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

   localparam logic signed [size_vmem-1:0] VMAX = {1'b0, {(size_vmem-1){1'b1}}};
   localparam logic signed [size_vmem-1:0] VMIN = {1'b1, {(size_vmem-1){1'b0}}};
   localparam logic [size_idx-1:0]         LAST = size_idx'(NUM_NEURONS - 1);

   state_t                        r_state;
   logic        [size_idx-1:0]    r_ptr;
   logic signed [size_vmem-1:0]   r_vmem   [NUM_NEURONS];
   logic        [size_refrac-1:0] r_refrac [NUM_NEURONS];

   logic signed [size_vmem-1:0]   r_threshold;
   logic        [3:0]             r_leak_shift;
   logic                          r_reset_mode;
   logic        [size_refrac-1:0] r_refrac_cfg;

   logic                          r_acc_ready;
   logic                          r_busy;
   logic                          r_spike_valid;
   logic        [size_idx-1:0]    r_spike_idx;
   logic                          r_step_done;
   logic signed [size_vmem-1:0]   r_rd_vmem;

   logic signed [size_vmem-1:0]   w_acc_old;
   logic signed [size_vmem-1:0]   w_acc_sum;
   logic                          w_acc_ovf;
   logic signed [size_vmem-1:0]   w_acc_sat;
   logic signed [size_vmem-1:0]   w_cur;
   logic signed [size_vmem-1:0]   w_leak;
   logic signed [size_vmem-1:0]   w_l;

   // NOTE: every signal gets a value before any condition so no latch is inferred.
   always_comb begin
      w_acc_old = r_vmem[bus.acc_idx];
      w_acc_sum = w_acc_old + bus.acc_weight;
      // Overflow only when both operands share a sign that the sum lost.
      w_acc_ovf = (w_acc_old[size_vmem-1] == bus.acc_weight[size_vmem-1]) &&
                  (w_acc_sum[size_vmem-1] != w_acc_old[size_vmem-1]);
      w_acc_sat = w_acc_sum;
      if (w_acc_ovf) begin
         w_acc_sat = w_acc_old[size_vmem-1] ? VMIN : VMAX;
      end

      w_cur  = r_vmem[r_ptr];
      w_leak = '0;
      if (r_leak_shift != 4'd0) begin
         w_leak = w_cur >>> r_leak_shift;
      end
      w_l = w_cur - w_leak;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the membrane file is small and must read zero after reset,
         // so it is built from resettable flops rather than a RAM.
         for (int i = 0; i < NUM_NEURONS; i++) begin
            r_vmem[i]   <= '0;
            r_refrac[i] <= '0;
         end
         r_state       <= S_IDLE;
         r_ptr         <= '0;
         r_threshold   <= '0;
         r_leak_shift  <= '0;
         r_reset_mode  <= 1'b0;
         r_refrac_cfg  <= '0;
         r_acc_ready   <= 1'b1;
         r_busy        <= 1'b0;
         r_spike_valid <= 1'b0;
         r_spike_idx   <= '0;
         r_step_done   <= 1'b0;
         r_rd_vmem     <= '0;
      end else begin
         r_spike_valid <= 1'b0;
         r_step_done   <= 1'b0;
         r_rd_vmem     <= r_vmem[rd_idx];

         case (r_state)
            S_IDLE: begin
               // Impulses to a refractory neuron are consumed and dropped.
               if (bus.acc_valid && (r_refrac[bus.acc_idx] == '0)) begin
                  r_vmem[bus.acc_idx] <= w_acc_sat;
               end
               if (step_start) begin
                  r_threshold  <= threshold;
                  r_leak_shift <= leak_shift;
                  r_reset_mode <= reset_mode;
                  r_refrac_cfg <= refrac_cfg;
                  r_ptr        <= '0;
                  r_state      <= S_SWEEP;
                  r_acc_ready  <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end

            S_SWEEP: begin
               if (r_refrac[r_ptr] != '0) begin
                  r_refrac[r_ptr] <= r_refrac[r_ptr] - 1'b1;
                  r_vmem[r_ptr]   <= '0;
               end else if (w_l >= r_threshold) begin
                  r_spike_valid   <= 1'b1;
                  r_spike_idx     <= r_ptr;
                  r_vmem[r_ptr]   <= r_reset_mode ? (w_l - r_threshold) : '0;
                  r_refrac[r_ptr] <= r_refrac_cfg;
               end else begin
                  r_vmem[r_ptr]   <= w_l;
               end

               if (r_ptr == LAST) begin
                  r_state     <= S_DONE;
                  r_step_done <= 1'b1;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end

            S_DONE: begin
               r_state     <= S_IDLE;
               r_acc_ready <= 1'b1;
               r_busy      <= 1'b0;
            end

            default: begin
               r_state     <= S_IDLE;
               r_acc_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.acc_ready   = r_acc_ready;
   assign bus.spike_valid = r_spike_valid;
   assign bus.spike_idx   = r_spike_idx;
   assign busy            = r_busy;
   assign step_done       = r_step_done;
   assign rd_vmem         = r_rd_vmem;

endmodule

// File: doc/neuron_lif_array.md
# neuron_lif_array

Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons with runtime-configurable threshold, leak, reset mode and refractory period. Between timesteps, weighted-sum impulses accumulate into per-neuron membrane potentials with saturation. A timestep pulse then sweeps every neuron in index order, applying leak and threshold and emitting a spike stream. The block replaces the single fixed-threshold neuron in the core's output stage and feeds the spike encoder.

## Interface
- NUM_NEURONS, 16: neurons in the array (≥2).
- size_vmem, 16: signed membrane potential and impulse width.
- size_idx, 4: neuron index width, $clog2(NUM_NEURONS).
- size_refrac, 3: refractory counter width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- acc_valid  in  1  impulse offered.
- acc_ready  out  1  high only in IDLE.
- acc_idx  in  size_idx  target neuron.
- acc_weight  in  size_vmem  signed impulse.
- step_start  in  1  timestep pulse; accepted only in IDLE.
- threshold  in  size_vmem  signed firing threshold; must be >0.
- leak_shift  in  4  leak = v>>>leak_shift; 0 disables leak.
- reset_mode  in  1  0: reset to zero, 1: subtract threshold.
- refrac_cfg  in  size_refrac  timesteps a neuron stays silent after firing.
- busy  out  1  high in SWEEP and DONE.
- spike_valid  out  1  one-cycle spike strobe.
- spike_idx  out  size_idx  index of the spiking neuron.
- step_done  out  1  one-cycle pulse at the end of a sweep.
- rd_idx  in  size_idx  debug read index.
- rd_vmem  out  size_vmem  vmem[rd_idx], registered.

## Operation
- State: vmem[N] (signed), refrac[N], FSM IDLE/SWEEP/DONE, sweep pointer ptr.
- On reset: all vmem, refrac and ptr go to 0, FSM goes to IDLE, and all outputs go to 0 except acc_ready. acc_ready is 1 from the first post-reset cycle. Reset aborts a sweep in progress with no step_done.
- IDLE, acc_valid&acc_ready:
  - If refrac[acc_idx]==0, vmem[acc_idx] <= sat(vmem+acc_weight).
  - Otherwise the impulse is consumed and dropped.
  - sat clips to [-2^(size_vmem-1), 2^(size_vmem-1)-1]. Overflow is detected from operand and result signs.
- IDLE, step_start: latch threshold, leak_shift, reset_mode and refrac_cfg. Set ptr=0 and go to SWEEP.
  - Config changes during a sweep have no effect.
- If acc_valid and step_start arrive in the same IDLE cycle, the impulse is applied first. The sweep then sees the updated vmem.
- SWEEP, one neuron per cycle at i=ptr. Compute L = vmem[i] - (vmem[i]>>>leak_shift), arithmetic shift, which cannot overflow. Then:
  - refrac[i]!=0: refrac[i]--, vmem[i] <= 0, no spike.
  - else L >= threshold (signed compare): spike. vmem[i] <= (reset_mode ? L-threshold : 0). refrac[i] <= refrac_cfg.
  - else vmem[i] <= L, no spike.
  - When ptr==NUM_NEURONS-1, go to DONE. Otherwise ptr++.
- DONE: step_done=1 for one cycle, then go to IDLE.
- step_start outside IDLE is ignored (no queuing). acc_ready=0 outside IDLE, so senders stall.
- rd_vmem <= vmem[rd_idx] every cycle, in all states.

## Timing
- Impulse accepted in cycle t is visible on rd_vmem at t+2 (rd_idx held).
- step_start accepted at t: neuron i is evaluated in cycle t+1+i.
- spike_valid/spike_idx for neuron i are registered and asserted in cycle t+2+i.
- step_done is asserted at t+NUM_NEURONS+1. It coincides with the spike strobe of the last neuron.
- busy is high t+1 … t+NUM_NEURONS+1. acc_ready returns high at t+NUM_NEURONS+2.
- Spikes appear in ascending index order. At most one spike strobe per cycle.
- Worst-case timestep period is NUM_NEURONS+2 cycles, including one IDLE cycle to accept step_start.

## Test plan
- Reset/idle: assert reset for 2 cycles mid-sweep, then release. Required: all rd_vmem reads 0, no step_done, acc_ready=1, spike_valid=0.
- Integrate-and-fire:
  - Setup: threshold=100, leak_shift=0, reset_mode=0, refrac_cfg=0. Add 60 to neuron 3 twice, then step_start.
  - Required: exactly one spike_valid, with spike_idx=3, 5 cycles after step_start. vmem[3]=0. step_done 17 cycles after step_start.
- Leak and subtract mode:
  - Setup: leak_shift=2, reset_mode=1, threshold=100. Add 200 to neuron 0, then step_start.
  - Required: L=150 → spike, vmem[0]=50. Next step: L=38, no spike.
- Saturation: add 32767 to neuron 5, then add 10. Required: vmem=32767. Then add -32768 three times. Required: vmem=-32768 (no wrap).
- Refractory:
  - Setup: refrac_cfg=2, threshold=10, neuron 1 = 20. Steps 1–4, with 50 added to neuron 1 before each of steps 2–4.
  - Required: spike at step 1. Impulses dropped and no spike at steps 2 and 3. Spike at step 4.
- Handshake corners:
  - acc_valid+step_start same cycle, impulse 15 to neuron 2, threshold 10. Required: spike for neuron 2 in that sweep.
  - step_start and acc_valid held during busy. Required: acc_ready=0, vmem unchanged, no second sweep.
